// File: rtl/mouse_position_tracker_if.sv
// Packet input and cursor/button output bundle between the PS/2 mouse
// transceiver and the position tracker.
interface mouse_position_tracker_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic               SEND_INTERRUPT;
  logic [7:0]         MouseStatus;
  logic [7:0]         MouseX;
  logic [7:0]         MouseY;
  logic [X_WIDTH-1:0] MousePosX;
  logic [Y_WIDTH-1:0] MousePosY;
  logic [2:0]         Buttons;
  logic               PosValid;
  logic               LeftClick;
  logic               RightClick;
  logic [7:0]         PacketCount;

  modport master (
    output SEND_INTERRUPT, MouseStatus, MouseX, MouseY,
    input  MousePosX, MousePosY, Buttons, PosValid, LeftClick, RightClick,
           PacketCount
  );

  modport slave (
    input  SEND_INTERRUPT, MouseStatus, MouseX, MouseY,
    output MousePosX, MousePosY, Buttons, PosValid, LeftClick, RightClick,
           PacketCount
  );
endinterface

// File: rtl/mouse_position_tracker.sv
// Two-stage tracker: captures PS/2 packets, accumulates clamped cursor
// position, and reports buttons, click pulses and an update strobe.
module mouse_position_tracker #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int Y_INVERT    = 1,
  parameter int DELTA_SHIFT = 0
) (
  input logic                    CLK,
  input logic                    RESET,
  mouse_position_tracker_if.slave bus
);

  localparam int AW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam int SW = ((AW > 9) ? AW : 9) + 2;
  localparam logic signed [SW-1:0] LIM_X = SW'(MAX_X - 1);
  localparam logic signed [SW-1:0] LIM_Y = SW'(MAX_Y - 1);
  localparam logic [X_WIDTH-1:0]   CTR_X = X_WIDTH'(MAX_X / 2);
  localparam logic [Y_WIDTH-1:0]   CTR_Y = Y_WIDTH'(MAX_Y / 2);

  function automatic logic signed [8:0] scale_delta(input logic       sgn,
                                                    input logic       ovf,
                                                    input logic [7:0] mag);
    logic signed [8:0] d;
    d = ovf ? 9'sd0 : $signed({sgn, mag});
    return d >>> DELTA_SHIFT;
  endfunction

  function automatic logic signed [SW-1:0] sat_axis(input logic signed [SW-1:0] s,
                                                    input logic signed [SW-1:0] lim);
    if (s < 0)   return '0;
    if (s > lim) return lim;
    return s;
  endfunction

  logic                    vld_p1_q;
  logic signed [8:0]       dx_p1_q, dy_p1_q;
  logic [2:0]              btn_p1_q;

  logic [X_WIDTH-1:0]      pos_x_q, pos_x_d;
  logic [Y_WIDTH-1:0]      pos_y_q, pos_y_d;
  logic [2:0]              btn_q, btn_d;
  logic                    vld_p2_q;
  logic                    lclk_q, lclk_d;
  logic                    rclk_q, rclk_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [SW-1:0]    sum_x, sum_y;

  // Stage 1: capture valid flag (control, reset) and packet data (no reset)
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) vld_p1_q <= 1'b0;
    else        vld_p1_q <= bus.SEND_INTERRUPT;
  end

  always_ff @(posedge CLK) begin
    if (bus.SEND_INTERRUPT) begin
      dx_p1_q  <= scale_delta(bus.MouseStatus[4], bus.MouseStatus[6], bus.MouseX);
      dy_p1_q  <= scale_delta(bus.MouseStatus[5], bus.MouseStatus[7], bus.MouseY);
      btn_p1_q <= bus.MouseStatus[2:0];
    end
  end

  // Stage 2: accumulate onto the position just written, then clamp
  always_comb begin
    sum_x   = $signed(SW'(pos_x_q)) + SW'(dx_p1_q);
    if (Y_INVERT != 0) sum_y = $signed(SW'(pos_y_q)) - SW'(dy_p1_q);
    else               sum_y = $signed(SW'(pos_y_q)) + SW'(dy_p1_q);
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    btn_d   = btn_q;
    cnt_d   = cnt_q;
    lclk_d  = 1'b0;
    rclk_d  = 1'b0;
    if (vld_p1_q) begin
      pos_x_d = X_WIDTH'(sat_axis(sum_x, LIM_X));
      pos_y_d = Y_WIDTH'(sat_axis(sum_y, LIM_Y));
      btn_d   = btn_p1_q;
      cnt_d   = cnt_q + 8'd1;
      lclk_d  = btn_p1_q[0] & ~btn_q[0];
      rclk_d  = btn_p1_q[1] & ~btn_q[1];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pos_x_q  <= CTR_X;
      pos_y_q  <= CTR_Y;
      btn_q    <= '0;
      cnt_q    <= '0;
      vld_p2_q <= 1'b0;
      lclk_q   <= 1'b0;
      rclk_q   <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      btn_q    <= btn_d;
      cnt_q    <= cnt_d;
      vld_p2_q <= vld_p1_q;
      lclk_q   <= lclk_d;
      rclk_q   <= rclk_d;
    end
  end

  assign bus.MousePosX   = pos_x_q;
  assign bus.MousePosY   = pos_y_q;
  assign bus.Buttons     = btn_q;
  assign bus.PosValid    = vld_p2_q;
  assign bus.LeftClick   = lclk_q;
  assign bus.RightClick  = rclk_q;
  assign bus.PacketCount = cnt_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed plus random packets checked against an integer-arithmetic cursor model.
module tb_mouse_position_tracker;

  localparam int XW = 10, YW = 10, MX = 640, MY = 480, YINV = 1, SH = 0;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mouse_position_tracker_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  mouse_position_tracker #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .MAX_X(MX), .MAX_Y(MY),
    .Y_INVERT(YINV), .DELTA_SHIFT(SH)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Reference state: what the outputs should show right now
  int       m_x, m_y, m_cnt;
  bit [2:0] m_btn;
  bit       m_pv, m_lc, m_rc;
  // Packet strobed in the previous cycle, due on the outputs at this edge
  bit       p_vld;
  bit [7:0] p_st, p_x, p_y;

  function automatic int delta(input bit sgn, input bit ovf, input bit [7:0] v);
    int d;
    d = sgn ? int'(v) - 256 : int'(v);
    if (ovf) d = 0;
    if (d < 0) d = -((-d + (1 << SH) - 1) / (1 << SH));
    else       d = d / (1 << SH);
    return d;
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v < 0)       return 0;
    if (v > lim - 1) return lim - 1;
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("posx",    int'(bus.MousePosX),   m_x);
    chk("posy",    int'(bus.MousePosY),   m_y);
    chk("buttons", int'(bus.Buttons),     int'(m_btn));
    chk("posvalid",int'(bus.PosValid),    int'(m_pv));
    chk("lclick",  int'(bus.LeftClick),   int'(m_lc));
    chk("rclick",  int'(bus.RightClick),  int'(m_rc));
    chk("count",   int'(bus.PacketCount), m_cnt);
  endtask

  task automatic model_reset();
    m_x = MX / 2; m_y = MY / 2; m_cnt = 0; m_btn = '0;
    m_pv = 0; m_lc = 0; m_rc = 0; p_vld = 0;
  endtask

  task automatic step(input bit si, input bit [7:0] st, input bit [7:0] x, input bit [7:0] y);
    int dy;
    @(negedge CLK);
    bus.SEND_INTERRUPT = si;
    bus.MouseStatus    = st;
    bus.MouseX         = x;
    bus.MouseY         = y;
    @(posedge CLK);
    #1;
    m_pv = 0; m_lc = 0; m_rc = 0;
    if (p_vld) begin
      dy    = delta(p_st[5], p_st[7], p_y);
      m_x   = clampi(m_x + delta(p_st[4], p_st[6], p_x), MX);
      m_y   = clampi(YINV ? m_y - dy : m_y + dy, MY);
      m_lc  = p_st[0] & ~m_btn[0];
      m_rc  = p_st[1] & ~m_btn[1];
      m_btn = p_st[2:0];
      m_cnt = (m_cnt + 1) % 256;
      m_pv  = 1;
    end
    p_vld = si; p_st = st; p_x = x; p_y = y;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus.SEND_INTERRUPT = 1'b0;
    RESET = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    bus.SEND_INTERRUPT = 1'b0;
    bus.MouseStatus = '0; bus.MouseX = '0; bus.MouseY = '0;
    model_reset();
    #12;
    do_reset();
    chk("rst_posx", int'(bus.MousePosX), 320);
    chk("rst_posy", int'(bus.MousePosY), 240);
    repeat (10) step(0, 8'h00, 8'h00, 8'h00);

    // positive move
    step(1, 8'h08, 8'h05, 8'h03);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("move_posx", int'(bus.MousePosX), 325);
    chk("move_posy", int'(bus.MousePosY), 237);
    chk("move_cnt",  int'(bus.PacketCount), 1);
    step(0, 8'h00, 8'h00, 8'h00);

    // clamp X at 0 and MAX_X-1
    repeat (2) step(1, 8'h18, 8'h00, 8'h00);
    step(1, 8'h18, 8'hEC, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("clamp_x0", int'(bus.MousePosX), 0);
    repeat (3) step(1, 8'h08, 8'hFF, 8'h00);
    step(1, 8'h08, 8'h64, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("clamp_xmax", int'(bus.MousePosX), 639);

    // clamp Y at 0 (positive dY moves up) and MAX_Y-1
    repeat (2) step(1, 8'h08, 8'h00, 8'hFF);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("clamp_y0", int'(bus.MousePosY), 0);
    repeat (3) step(1, 8'h28, 8'h00, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("clamp_ymax", int'(bus.MousePosY), 479);

    // X overflow discards X only
    step(1, 8'h48, 8'h7F, 8'h02);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("ovf_posx", int'(bus.MousePosX), 639);
    chk("ovf_posy", int'(bus.MousePosY), 477);

    // back-to-back packets
    do_reset();
    step(1, 8'h08, 8'h01, 8'h00);
    step(1, 8'h08, 8'h02, 8'h00);
    chk("b2b_x1", int'(bus.MousePosX), 321);
    step(1, 8'h08, 8'h03, 8'h00);
    chk("b2b_x2", int'(bus.MousePosX), 323);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("b2b_x3", int'(bus.MousePosX), 326);
    chk("b2b_pv", int'(bus.PosValid), 1);
    step(0, 8'h00, 8'h00, 8'h00);

    // clicks
    step(1, 8'h09, 8'h00, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("click_l", int'(bus.LeftClick), 1);
    step(1, 8'h09, 8'h00, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("click_hold", int'(bus.LeftClick), 0);
    step(1, 8'h0A, 8'h00, 8'h00);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("click_r", int'(bus.RightClick), 1);
    chk("click_r_l", int'(bus.LeftClick), 0);

    // reset right after a strobe drops the packet
    step(1, 8'h08, 8'h10, 8'h10);
    do_reset();
    repeat (3) step(0, 8'h00, 8'h00, 8'h00);
    chk("midrst_x", int'(bus.MousePosX), 320);
    chk("midrst_y", int'(bus.MousePosY), 240);

    // random packets, including overflow bits and bursts
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    step(0, 8'h00, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
